ip_header_check: RTL and testbench

Receive-side counterpart of the IPv4 header checksum generator. It consumes an incoming IPv4 header as a stream of 32-bit big-endian words and computes the ones'-complement sum over all header words, including the received checksum field. It validates version, IHL, fragmentation and destination address, then presents extracted fields plus pass/fail flags to the RX packet filter, which drops any packet whose `out_ok` is low.

---
 rtl/ip_hdr_pkg.sv | 27 ++
 rtl/ones_comp_fold.sv | 17 +
 rtl/ip_header_check.sv | 150 +++++++++++++++
 tb/tb_ip_header_check.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_hdr_pkg.sv
// rtl/ip_hdr_pkg.sv - shared constants, state encoding and helpers for the IPv4 RX header checker (IP_HDR_OPTIONS_EN selects option-word support)
package ip_hdr_pkg;

    localparam logic [3:0]  IP_VERSION_4  = 4'd4;
    localparam logic [3:0]  IP_IHL_MIN    = 4'd5;
    localparam int          MF_BIT        = 13;
    localparam logic [12:0] FRAG_OFF_MASK = 13'h1FFF;

`ifdef IP_HDR_OPTIONS_EN
    // Word index has to reach 14 for a 15-word header.
    localparam int CNT_W = 4;
`else
    // Fixed 5-word header: indices 0..4 plus the post-increment value 5.
    localparam int CNT_W = 3;
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HDR  = 1'b1
    } hdr_state_t;

    // Sum of the two big-endian 16-bit halves of one header word.
    function automatic logic [16:0] word_sum(input logic [31:0] w);
        return {1'b0, w[31:16]} + {1'b0, w[15:0]};
    endfunction

endpackage

// File: rtl/ones_comp_fold.sv
// rtl/ones_comp_fold.sv - combinational 20-to-16 bit ones'-complement double fold
module ones_comp_fold (
    input  logic [19:0] sum,
    output logic [15:0] folded
);

    logic [16:0] s1;
    logic [15:0] s2;

    // First fold can leave at most one carry, which the second fold absorbs without overflow.
    always_comb begin
        s1     = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
        s2     = s1[15:0] + {15'd0, s1[16]};
        folded = s2;
    end

endmodule

// File: rtl/ip_header_check.sv
// rtl/ip_header_check.sv - IPv4 RX header checker: checksum, version, IHL, fragment and destination validation (IP_HDR_OPTIONS_EN enables option words)
module ip_header_check
    import ip_hdr_pkg::*;
#(
    parameter logic [31:0] LOCAL_IP  = 32'hC0A8_0001,
    parameter bit          CHECK_DST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_sop,
    output logic        busy,
    output logic        out_done,
    output logic        out_ok,
    output logic        err_version,
    output logic        err_ihl,
    output logic        err_csum,
    output logic        err_dst,
    output logic        err_frag,
    output logic [15:0] hdr_total_len,
    output logic [7:0]  hdr_protocol,
    output logic [31:0] hdr_src_ip,
    output logic [3:0]  hdr_ihl
);

    hdr_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [19:0]      acc;

    // Working copies of the header being accumulated; the hdr_* outputs only
    // take these on completion so a following header cannot disturb a result.
    logic [3:0]  ver_q;
    logic [3:0]  ihl_q;
    logic [15:0] tlen_q;
    logic [13:0] frag_q;
    logic [7:0]  proto_q;
    logic [31:0] src_q;
    logic [31:0] dst_q;

    logic             sop_take;
    logic             word_take;
    logic             is_last;
    logic [CNT_W-1:0] last_idx;
    logic [19:0]      acc_next;
    logic [15:0]      csum_folded;
    logic [31:0]      dst_eff;
    logic             f_version;
    logic             f_ihl;
    logic             f_csum;
    logic             f_dst;
    logic             f_frag;

    ones_comp_fold u_fold (
        .sum    (acc_next),
        .folded (csum_folded)
    );

    // Accept decode, end-of-header detection and the check results for the word being taken.
    always_comb begin
        sop_take  = in_valid & in_sop;
        word_take = (state == ST_HDR) & in_valid & ~in_sop;
`ifdef IP_HDR_OPTIONS_EN
        // Short IHL is flagged but still consumes the minimum five words.
        last_idx  = (ihl_q < IP_IHL_MIN) ? (IP_IHL_MIN - 4'd1) : (ihl_q - 4'd1);
`else
        last_idx  = CNT_W'(4);
`endif
        is_last   = word_take & (cnt == last_idx);
        acc_next  = acc + {3'd0, word_sum(in_data)};

        // In the 5-word case the destination arrives with the last word itself.
        dst_eff   = (cnt == CNT_W'(4)) ? in_data : dst_q;

        f_version = (ver_q != IP_VERSION_4);
`ifdef IP_HDR_OPTIONS_EN
        f_ihl     = (ihl_q < IP_IHL_MIN);
`else
        f_ihl     = (ihl_q != IP_IHL_MIN);
`endif
        f_csum    = (csum_folded != 16'hFFFF);
        f_frag    = frag_q[MF_BIT] | ((frag_q[12:0] & FRAG_OFF_MASK) != 13'd0);
        f_dst     = CHECK_DST && (dst_eff != LOCAL_IP);
    end

    assign busy = (state == ST_HDR);

    // Header FSM: word capture, checksum accumulation and registered result publication.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            acc           <= '0;
            ver_q         <= '0;
            ihl_q         <= '0;
            tlen_q        <= '0;
            frag_q        <= '0;
            proto_q       <= '0;
            src_q         <= '0;
            dst_q         <= '0;
            out_done      <= 1'b0;
            out_ok        <= 1'b0;
            err_version   <= 1'b0;
            err_ihl       <= 1'b0;
            err_csum      <= 1'b0;
            err_dst       <= 1'b0;
            err_frag      <= 1'b0;
            hdr_total_len <= '0;
            hdr_protocol  <= '0;
            hdr_src_ip    <= '0;
            hdr_ihl       <= '0;
        end else begin
            out_done <= 1'b0;
            if (sop_take) begin
                // A sop always starts over, discarding any partial header silently.
                state  <= ST_HDR;
                cnt    <= CNT_W'(1);
                acc    <= {3'd0, word_sum(in_data)};
                ver_q  <= in_data[31:28];
                ihl_q  <= in_data[27:24];
                tlen_q <= in_data[15:0];
            end else if (word_take) begin
                cnt <= cnt + CNT_W'(1);
                acc <= acc_next;
                case (cnt)
                    CNT_W'(1): frag_q  <= in_data[13:0];
                    CNT_W'(2): proto_q <= in_data[23:16];
                    CNT_W'(3): src_q   <= in_data;
                    CNT_W'(4): dst_q   <= in_data;
                    default:   ;
                endcase
                if (is_last) begin
                    state         <= ST_IDLE;
                    out_done      <= 1'b1;
                    out_ok        <= ~(f_version | f_ihl | f_csum | f_dst | f_frag);
                    err_version   <= f_version;
                    err_ihl       <= f_ihl;
                    err_csum      <= f_csum;
                    err_dst       <= f_dst;
                    err_frag      <= f_frag;
                    hdr_total_len <= tlen_q;
                    hdr_protocol  <= (cnt == CNT_W'(2)) ? in_data[23:16] : proto_q;
                    hdr_src_ip    <= (cnt == CNT_W'(3)) ? in_data : src_q;
                    hdr_ihl       <= ihl_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_ip_header_check.sv
// tb/tb_ip_header_check.sv - table-driven self-checking bench for ip_header_check
module tb_ip_header_check;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_sop;
    logic        busy, out_done, out_ok;
    logic        err_version, err_ihl, err_csum, err_dst, err_frag;
    logic [15:0] hdr_total_len;
    logic [7:0]  hdr_protocol;
    logic [31:0] hdr_src_ip;
    logic [3:0]  hdr_ihl;

    always #5 clk = ~clk;

    ip_header_check #(
        .LOCAL_IP  (32'hAE24_1E2B),
        .CHECK_DST (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_sop        (in_sop),
        .busy          (busy),
        .out_done      (out_done),
        .out_ok        (out_ok),
        .err_version   (err_version),
        .err_ihl       (err_ihl),
        .err_csum      (err_csum),
        .err_dst       (err_dst),
        .err_frag      (err_frag),
        .hdr_total_len (hdr_total_len),
        .hdr_protocol  (hdr_protocol),
        .hdr_src_ip    (hdr_src_ip),
        .hdr_ihl       (hdr_ihl)
    );

    typedef struct packed {
        logic [31:0] w0, w1, w2, w3, w4;
        logic [4:0]  flags;   // {version, ihl, csum, dst, frag}
        logic        ok;
        logic [15:0] tlen;
        logic [7:0]  proto;
        logic [31:0] src;
        logic [3:0]  ihl;
        logic [3:0]  stall_at;
        logic [3:0]  stall_n;
    } vec_t;

    typedef struct packed {
        logic [4:0]  flags;
        logic        ok;
        logic [15:0] tlen;
        logic [7:0]  proto;
        logic [31:0] src;
        logic [3:0]  ihl;
    } res_t;

    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   sop_cyc = 0;
    int   pulses = 0;
    res_t rec     [64];
    int   rec_lat [64];
    int   rec_cyc [64];
    vec_t tbl [8];

    // Cycle count and most recent sop accepted.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (in_valid && in_sop) sop_cyc = cyc;
    end

    // Capture every result pulse.
    always @(negedge clk) begin
        if (out_done) begin
            rec[pulses % 64] = '{flags: {err_version, err_ihl, err_csum, err_dst, err_frag},
                                 ok: out_ok, tlen: hdr_total_len, proto: hdr_protocol,
                                 src: hdr_src_ip, ihl: hdr_ihl};
            rec_lat[pulses % 64] = cyc - sop_cyc;
            rec_cyc[pulses % 64] = cyc;
            pulses = pulses + 1;
        end
    end

    function automatic vec_t mk(input logic [31:0] a, b, c, d, e, input logic [4:0] f,
                                input logic [15:0] tl, input logic [3:0] ih,
                                input logic [3:0] sa, input logic [3:0] sn);
        vec_t v;
        v.w0 = a; v.w1 = b; v.w2 = c; v.w3 = d; v.w4 = e;
        v.flags = f; v.ok = (f == 5'b0); v.tlen = tl; v.proto = 8'h06;
        v.src = d; v.ihl = ih; v.stall_at = sa; v.stall_n = sn;
        return v;
    endfunction

    function automatic logic [31:0] wsel(input vec_t v, input int i);
        case (i)
            0: return v.w0;
            1: return v.w1;
            2: return v.w2;
            3: return v.w3;
            default: return v.w4;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put(input logic [31:0] d, input logic v, input logic s);
        @(negedge clk);
        in_data = d; in_valid = v; in_sop = s;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(32'hDEAD_BEEF, 1'b0, 1'b0);
    endtask

    task automatic send(input vec_t v);
        for (int i = 0; i < 5; i++) begin
            if (v.stall_at != 4'd0 && int'(v.stall_at) == i)
                for (int k = 0; k < int'(v.stall_n); k++) put(32'h0BAD_F00D, 1'b0, 1'b0);
            put(wsel(v, i), 1'b1, (i == 0));
        end
    endtask

    task automatic snap(output int p);
        @(posedge clk);
        #1;
        p = pulses;
    endtask

    task automatic chk_rec(input string tag, input int idx, input vec_t v, input int lat);
        res_t r;
        r = rec[idx % 64];
        chk({tag, ".flags"}, 64'(r.flags), 64'(v.flags));
        chk({tag, ".ok"},    64'(r.ok),    64'(v.ok));
        chk({tag, ".tlen"},  64'(r.tlen),  64'(v.tlen));
        chk({tag, ".proto"}, 64'(r.proto), 64'(v.proto));
        chk({tag, ".src"},   64'(r.src),   64'(v.src));
        chk({tag, ".ihl"},   64'(r.ihl),   64'(v.ihl));
        chk({tag, ".lat"},   64'(rec_lat[idx % 64]), 64'(lat));
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, 64'({busy, out_done, out_ok, err_version, err_ihl, err_csum, err_dst, err_frag}), 64'd0);
        chk({tag, ".fields"}, 64'({hdr_total_len, hdr_protocol, hdr_src_ip, hdr_ihl}), 64'd0);
    endtask

    initial begin
        int   base, now;
        vec_t ref_v, bad_v;

        ref_v = mk(32'h4500_0030, 32'h4422_4000, 32'h8006_442E, 32'h8C7C_19AC, 32'hAE24_1E2B, 5'b00000, 16'h0030, 4'd5, 4'd0, 4'd0);
        bad_v = mk(32'h4500_0030, 32'h4422_4000, 32'h8006_0000, 32'h8C7C_19AC, 32'hAE24_1E2B, 5'b00100, 16'h0030, 4'd5, 4'd0, 4'd0);
        tbl[0] = ref_v;
        tbl[1] = bad_v;
        tbl[2] = mk(32'h4500_0030, 32'h4422_4000, 32'h8006_442E, 32'h8C7C_19AC, 32'hAE24_1E2B, 5'b00000, 16'h0030, 4'd5, 4'd3, 4'd3);
        tbl[3] = mk(32'h6500_0030, 32'h4422_4000, 32'h8006_242E, 32'h8C7C_19AC, 32'hAE24_1E2B, 5'b10000, 16'h0030, 4'd5, 4'd0, 4'd0);
        tbl[4] = mk(32'h4500_0030, 32'h4422_2000, 32'h8006_642E, 32'h8C7C_19AC, 32'hAE24_1E2B, 5'b00001, 16'h0030, 4'd5, 4'd0, 4'd0);
        tbl[5] = mk(32'h4600_0034, 32'h4422_4000, 32'h8006_432A, 32'h8C7C_19AC, 32'hAE24_1E2B, 5'b01000, 16'h0034, 4'd6, 4'd0, 4'd0);
        tbl[6] = mk(32'h4500_0030, 32'h4422_4000, 32'h8006_442D, 32'h8C7C_19AC, 32'hAE24_1E2C, 5'b00010, 16'h0030, 4'd5, 4'd0, 4'd0);
        tbl[7] = mk(32'h4500_0030, 32'h4422_0001, 32'h8006_842D, 32'h8C7C_19AC, 32'hAE24_1E2B, 5'b00001, 16'h0030, 4'd5, 4'd0, 4'd0);

        reset = 1'b0; in_data = '0; in_valid = 1'b0; in_sop = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_zero("reset_init");
        reset = 1'b0;

        // Valid word without sop while idle must be ignored.
        put(32'h4500_0030, 1'b1, 1'b0);
        put(32'h4422_4000, 1'b1, 1'b0);
        idle(1);
        chk("stray_busy", 64'(busy), 64'd0);
        idle(2);

        for (int i = 0; i < 8; i++) begin
            snap(base);
            send(tbl[i]);
            idle(3);
            snap(now);
            chk($sformatf("vec%0d.pulses", i), 64'(now - base), 64'd1);
            chk_rec($sformatf("vec%0d", i), base, tbl[i], 4 + ((tbl[i].stall_at != 4'd0) ? int'(tbl[i].stall_n) : 0));
        end

        // Restart: partial header then a fresh sop in the word-2 slot.
        snap(base);
        put(32'h6500_0030, 1'b1, 1'b1);
        put(32'h4422_4000, 1'b1, 1'b0);
        send(ref_v);
        idle(3);
        snap(now);
        chk("restart.pulses", 64'(now - base), 64'd1);
        chk_rec("restart", base, ref_v, 4);

        // Reset mid-header after word 3.
        snap(base);
        put(ref_v.w0, 1'b1, 1'b1);
        put(ref_v.w1, 1'b1, 1'b0);
        put(ref_v.w2, 1'b1, 1'b0);
        put(ref_v.w3, 1'b1, 1'b0);
        @(negedge clk);
        chk("midhdr_busy", 64'(busy), 64'd1);
        in_valid = 1'b0; in_sop = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk_zero("reset_mid");
        @(negedge clk);
        reset = 1'b0;
        send(ref_v);
        idle(3);
        snap(now);
        chk("reset.pulses", 64'(now - base), 64'd1);
        chk_rec("after_reset", base, ref_v, 4);

        // Back-to-back headers with no gap.
        snap(base);
        send(ref_v);
        send(bad_v);
        idle(3);
        snap(now);
        chk("b2b.pulses", 64'(now - base), 64'd2);
        chk_rec("b2b0", base, ref_v, 4);
        chk_rec("b2b1", base + 1, bad_v, 4);
        chk("b2b.spacing", 64'(rec_cyc[(base + 1) % 64] - rec_cyc[base % 64]), 64'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
